// File: rtl/freq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_gen_pkg
// Description : Shared types and defaults for the programmable square-wave
//               generator: controller state encoding, default data width,
//               default system clock frequency and the highest frequency
//               that can be produced (half the system clock).
// Revision    : 1.0 - initial release
// ============================================================================
package freq_gen_pkg;

    localparam int unsigned W_DEFAULT            = 32;
    localparam int unsigned SYS_CLK_FREQ_DEFAULT = 50_000_000;
    localparam int unsigned F_MAX                = SYS_CLK_FREQ_DEFAULT / 2;

    // IDLE: output stopped, DIV: divider busy, RUN: output toggling
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_restoring.sv
`default_nettype none
// ============================================================================
// Module      : div_restoring
// Description : Unsigned sequential restoring divider, one quotient bit per
//               cycle. The divisor is one bit wider than the dividend so a
//               doubled W-bit value fits without overflow.
// Ports       : clk, rst_n (async, active-low)
//               start     - load operands (ignored while busy)
//               dividend  - W-bit numerator
//               divisor   - (W+1)-bit denominator
//               done      - one-cycle pulse, quotient valid in that cycle
//               quotient  - W-bit floor(dividend / divisor)
// Latency     : done rises W cycles after the start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module div_restoring
    import freq_gen_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W:0]   divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W);

    logic [W:0]    r_rem;
    logic [W-1:0]  r_quo;     // dividend shifts out of the top, quotient bits in at the bottom
    logic [W:0]    r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_diff;
    logic          w_ge;

    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_rem  <= '0;
                r_quo  <= dividend;
                r_div  <= divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                // Partial remainder always ends below the divisor, so it fits in W+1 bits
                r_rem <= (W+1)'(w_ge ? w_diff : w_shift);
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/freq_gen.sv
`default_nettype none
// ============================================================================
// Module      : freq_gen
// Description : Programmable square-wave generator. A setpoint in Hz is
//               accepted over valid/ready, converted by a sequential divider
//               to a half-period N = floor(SYS_CLK_FREQ / (2*freq_set)),
//               clamped to at least 1, and applied at the next output toggle.
// Ports       : sys_clk, sys_rst_n (async, active-low)
//               freq_set  - requested frequency in Hz
//               set_valid - freq_set valid
//               set_ready - a setpoint can be accepted
//               clk_out   - generated square wave (registered)
//               locked    - clk_out runs at the last accepted setpoint
//               err       - one-cycle out-of-range pulse (optional)
// Options     : FREQ_GEN_RANGE_CHECK_EN - reject freq_set > SYS_CLK_FREQ/2
//               with an err pulse instead of clamping to SYS_CLK_FREQ/2.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = SYS_CLK_FREQ_DEFAULT,
    parameter int unsigned W            = W_DEFAULT
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [W-1:0] freq_set,
    input  logic         set_valid,
    output logic         set_ready,
    output logic         clk_out,
`ifdef FREQ_GEN_RANGE_CHECK_EN
    output logic         locked,
    output logic         err
`else
    output logic         locked
`endif
);

    localparam logic [W-1:0] c_dividend = W'(SYS_CLK_FREQ);

    state_t        r_state;
    logic [W-1:0]  r_n_active;
    logic [W-1:0]  r_n_pending;
    logic          r_pend;       // r_n_pending waits for the next toggle
    logic [W-1:0]  r_cnt;
    logic          r_clk;
    logic          r_run;        // waveform is toggling (also during DIV)
    logic          r_stop;       // stop after the current high phase
    logic          r_ready;
    logic          r_locked;

    logic          w_xfer;
    logic          w_zero;
    logic          w_start;
    logic          w_boundary;
    logic          w_div_done;
    logic [W-1:0]  w_div_quo;
    logic [W-1:0]  w_n_new;

`ifdef FREQ_GEN_RANGE_CHECK_EN
    localparam logic [W-1:0] c_f_max = W'(SYS_CLK_FREQ / 2);
    logic r_err;
    logic w_oor;
    assign w_oor   = (freq_set > c_f_max);
    assign w_start = w_xfer && !w_zero && !w_oor;
    assign err     = r_err;
`else
    assign w_start = w_xfer && !w_zero;
`endif

    assign w_xfer     = set_valid && r_ready;
    assign w_zero     = (freq_set == '0);
    assign w_boundary = r_run && (r_cnt == r_n_active - W'(1));
    assign w_n_new    = (w_div_quo == '0) ? W'(1) : w_div_quo;

    div_restoring #(
        .W(W)
    ) u_div (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .start    (w_start),
        .dividend (c_dividend),
        .divisor  ({freq_set, 1'b0}),
        .done     (w_div_done),
        .quotient (w_div_quo)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_n_active  <= '0;
            r_n_pending <= '0;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
            r_clk       <= 1'b0;
            r_run       <= 1'b0;
            r_stop      <= 1'b0;
            r_ready     <= 1'b1;
            r_locked    <= 1'b0;
`ifdef FREQ_GEN_RANGE_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
`ifdef FREQ_GEN_RANGE_CHECK_EN
            r_err <= 1'b0;
`endif
            // Half-period counter and toggle; pending N swaps in only here
            if (r_run) begin
                if (w_boundary) begin
                    r_cnt <= '0;
                    if (r_stop && r_clk) begin
                        r_clk   <= 1'b0;
                        r_run   <= 1'b0;
                        r_stop  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_clk <= ~r_clk;
                        if (r_pend) begin
                            r_n_active <= r_n_pending;
                            r_pend     <= 1'b0;
                            r_locked   <= 1'b1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + W'(1);
                end
            end

            // Division finished: install directly when stopped, otherwise
            // hold as pending. A toggle in this very cycle counts as the
            // boundary, so the new N governs the phase that starts now.
            if (r_state == DIV && w_div_done) begin
                r_ready <= 1'b1;
                r_state <= RUN;
                if (r_run) begin
                    if (w_boundary) begin
                        r_n_active <= w_n_new;
                        r_locked   <= 1'b1;
                        r_pend     <= 1'b0;
                    end else begin
                        r_n_pending <= w_n_new;
                        r_pend      <= 1'b1;
                    end
                end else begin
                    r_n_active <= w_n_new;
                    r_cnt      <= '0;
                    r_run      <= 1'b1;
                    r_locked   <= 1'b1;
                end
            end

            // Handshake; ready is never high while DIV, so no overlap with done
            if (w_xfer) begin
                if (w_zero) begin
                    r_locked <= 1'b0;
                    r_pend   <= 1'b0;
                    if (r_run && r_clk && !w_boundary) begin
                        r_stop <= 1'b1;
                    end else begin
                        r_run   <= 1'b0;
                        r_clk   <= 1'b0;
                        r_cnt   <= '0;
                        r_stop  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
`ifdef FREQ_GEN_RANGE_CHECK_EN
                else if (w_oor) begin
                    r_err <= 1'b1;
                end
`endif
                else begin
                    r_state  <= DIV;
                    r_ready  <= 1'b0;
                    r_locked <= 1'b0;
                    r_stop   <= 1'b0;
                    r_pend   <= 1'b0;
                end
            end
        end
    end

    assign set_ready = r_ready;
    assign clk_out   = r_clk;
    assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_freq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_gen
// Description : Self-checking bench for freq_gen. Directed table of setpoints
//               with hand-computed half-periods, hand-written corner-case
//               sequences, and random setpoint traffic compared every cycle
//               against an event-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_gen;

    localparam int unsigned SYS = 50_000_000;
    localparam int unsigned WD  = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [WD-1:0] fset  = '0;
    logic          set_ready;
    logic          clk_out;
    logic          locked;
    logic          err_w;

    always #5 clk = ~clk;

    freq_gen #(
        .SYS_CLK_FREQ(SYS),
        .W(WD)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .freq_set  (fset),
        .set_valid (valid),
        .set_ready (set_ready),
        .clk_out   (clk_out),
`ifdef FREQ_GEN_RANGE_CHECK_EN
        .locked    (locked),
        .err       (err_w)
`else
        .locked    (locked)
`endif
    );

`ifndef FREQ_GEN_RANGE_CHECK_EN
    assign err_w = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: absolute edge times instead of a counter
    longint cyc;
    bit     m_run, m_clk, m_ready, m_locked, m_err, m_pend, m_stop;
    longint m_n, m_pend_n, m_div_n, m_next, m_done_at;

    typedef struct {
        logic [31:0] freq;
        int          exp_n;
        bit          oor;
    } vec_t;
    vec_t tbl [10];

    function automatic longint ref_n(input longint f);
        longint q;
        q = longint'(SYS) / (2 * f);
        return (q == 0) ? 1 : q;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_clk = 0; m_ready = 1; m_locked = 0; m_err = 0;
        m_pend = 0; m_stop = 0; m_n = 0; m_next = 0; m_done_at = 0;
    endtask

    task automatic model_edge(input logic v, input logic [WD-1:0] f);
        bit p_run, p_clk, p_ready, bnd, oor;
        p_run = m_run; p_clk = m_clk; p_ready = m_ready;
        bnd = m_run && (cyc == m_next);
        m_err = 0;
        if (bnd) begin
            if (m_stop && m_clk) begin
                m_clk = 0; m_run = 0; m_stop = 0;
            end else begin
                m_clk = !m_clk;
                if (m_pend) begin m_n = m_pend_n; m_pend = 0; m_locked = 1; end
                m_next = cyc + m_n;
            end
        end
        if (!p_ready && cyc == m_done_at) begin
            m_ready = 1;
            if (m_run) begin
                if (bnd) begin m_n = m_div_n; m_locked = 1; m_next = cyc + m_n; end
                else begin m_pend_n = m_div_n; m_pend = 1; end
            end else begin
                m_run = 1; m_n = m_div_n; m_next = cyc + m_n; m_locked = 1;
            end
        end
        oor = 0;
`ifdef FREQ_GEN_RANGE_CHECK_EN
        oor = (longint'(f) > longint'(SYS / 2));
`endif
        if (v && p_ready) begin
            if (f == 0) begin
                m_locked = 0; m_pend = 0;
                if (p_run && p_clk && !bnd) m_stop = 1;
                else begin m_run = 0; m_clk = 0; m_stop = 0; end
            end else if (oor) begin
                m_err = 1;
            end else begin
                m_ready = 0; m_done_at = cyc + 33; m_div_n = ref_n(longint'(f));
                m_locked = 0; m_stop = 0; m_pend = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_edge(valid, fset);
        #1;
        check("model", {clk_out, set_ready, locked, err_w}, {m_clk, m_ready, m_locked, m_err});
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!set_ready && c < 1000) begin step(); c++; end
    endtask

    task automatic count_while(input logic lvl, output int c);
        c = 0;
        while (clk_out === lvl && c < 10000) begin step(); c++; end
    endtask

    task automatic accept(input logic [WD-1:0] f);
        int c;
        wait_ready(c);
        valid = 1'b1; fset = f;
        step();
        valid = 1'b0;
    endtask

    task automatic go_idle();
        int c;
        accept('0);
        count_while(1'b1, c);
        check("idle_reached", clk_out, 0);
        step();
    endtask

    // Called just after a step: reset lands mid-cycle, away from any edge
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_clk"}, clk_out, 0);
        check({tag, "_ready"}, set_ready, 1);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err_w, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, h, l, r;
        logic prev, lk_before;

        tbl[0] = '{32'd1_000_000,  25, 1'b0};
        tbl[1] = '{32'd500_000,    50, 1'b0};
        tbl[2] = '{32'd25_000_000,  1, 1'b0};
        tbl[3] = '{32'd30_000_000,  1, 1'b1};
        tbl[4] = '{32'd3_000_000,   8, 1'b0};
        tbl[5] = '{32'd2_000_000,  12, 1'b0};
        tbl[6] = '{32'd12_345_678,  2, 1'b0};
        tbl[7] = '{32'd16_666_667,  1, 1'b0};
        tbl[8] = '{32'd333_333,    75, 1'b0};
        tbl[9] = '{32'd25_000_001,  1, 1'b1};

        cyc = 0;
        model_reset();
        step();
        step();
        check("rst_clk", clk_out, 0);
        check("rst_ready", set_ready, 1);
        check("rst_locked", locked, 0);
        check("rst_err", err_w, 0);
        rst_n = 1'b1;
        step();

        // Directed table, each row started from a stopped output
        for (int i = 0; i < 10; i++) begin
            go_idle();
            accept(tbl[i].freq);
`ifdef FREQ_GEN_RANGE_CHECK_EN
            if (tbl[i].oor) begin
                check("oor_err_pulse", err_w, 1);
                check("oor_ready", set_ready, 1);
                step();
                check("oor_err_clear", err_w, 0);
                check("oor_clk_idle", clk_out, 0);
                continue;
            end
`endif
            check("accept_ready_low", set_ready, 0);
            wait_ready(c);
            check("ready_low_cycles", c, 33);
            count_while(1'b0, c2);
            check("first_toggle", c + c2, 33 + tbl[i].exp_n);
            check("locked_run", locked, 1);
            count_while(1'b1, h);
            check("high_phase", h, tbl[i].exp_n);
            count_while(1'b0, l);
            check("low_phase", l, tbl[i].exp_n);
        end

        // Retune 1 MHz -> 500 kHz while running
        go_idle();
        accept(32'd1_000_000);
        count_while(1'b0, c);
        repeat (7) step();
        accept(32'd500_000);
        check("retune_locked_drop", locked, 0);
        wait_ready(c);
        lk_before = locked; prev = clk_out; c = 0;
        while (clk_out === prev && c < 200) begin lk_before = locked; step(); c++; end
        check("retune_locked_before", lk_before, 0);
        check("retune_locked_after", locked, 1);
        count_while(clk_out, h);
        check("retune_phase", h, 50);

        // Zero setpoint while the output is high
        go_idle();
        accept(32'd1_000_000);
        count_while(1'b0, c);
        repeat (3) step();
        accept('0);
        check("zero_ready", set_ready, 1);
        check("zero_locked", locked, 0);
        check("zero_clk_high", clk_out, 1);
        count_while(1'b1, h);
        check("zero_high_rest", h, 21);
        l = 0;
        for (int k = 0; k < 200; k++) begin step(); if (!clk_out) l++; end
        check("zero_stays_low", l, 200);

        // set_valid held through DIV with a changing freq_set
        go_idle();
        accept(32'd1_000_000);
        c = 0;
        valid = 1'b1;
        while (!set_ready && c < 100) begin
            fset = $urandom_range(1, 40_000_000);
            step();
            c++;
        end
        check("held_ready_wait", c, 33);
        fset = 32'd2_000_000;
        step();
        valid = 1'b0;
        check("held_next_accept", set_ready, 0);
        wait_ready(c);
        prev = clk_out;
        count_while(prev, c);
        check("held_locked", locked, 1);
        count_while(clk_out, h);
        check("held_phase", h, 12);

`ifdef FREQ_GEN_RANGE_CHECK_EN
        // Out-of-range setpoint while running leaves the waveform alone
        go_idle();
        accept(32'd1_000_000);
        count_while(1'b0, c);
        repeat (2) step();
        accept(32'd30_000_000);
        check("run_oor_err", err_w, 1);
        check("run_oor_locked", locked, 1);
        check("run_oor_ready", set_ready, 1);
        step();
        check("run_oor_err_clear", err_w, 0);
        count_while(1'b1, h);
        check("run_oor_high", h, 21);
        count_while(1'b0, l);
        check("run_oor_low", l, 25);
`endif

        // Reset while running, then reset during division
        go_idle();
        accept(32'd1_000_000);
        repeat (100) step();
        async_reset("run_rst");
        accept(32'd1_000_000);
        repeat (10) step();
        async_reset("div_rst");
        h = 0;
        for (int k = 0; k < 100; k++) begin step(); if (clk_out) h++; end
        check("div_rst_no_retune", h, 0);
        check("div_rst_locked", locked, 0);

        // Random setpoint traffic against the reference model
        for (int i = 0; i < 6000; i++) begin
            valid = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 19);
            if (r == 0)      fset = '0;
            else if (r == 1) fset = $urandom_range(25_000_001, 60_000_000);
            else             fset = $urandom_range(125_000, 30_000_000);
            step();
        end
        valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
